// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants and the 3-bit color type, used by the
// sync generator and by the painter that feeds it.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_CLK_DIV   = 2;

    typedef logic [2:0] color_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with a configurable reset value; exposes the
// first stage as well as the last so callers can tap the midpoint.
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] first_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {DEPTH{RST_VAL}};
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign first_o = stage_q[0];
    assign data_o  = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: pixel divider, h/v counters, sync/blank
// decode aligned to the painter's rgb. Define VGA_TEST_PATTERN_EN for color bars.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  color_t      color_in,
    output logic [10:0] pixelX,
    output logic [9:0]  pixelY,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output color_t      rgb,
    output logic        frame_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_STOP    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_STOP    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             pix_tick;
    logic             frame_tick_q;
    logic             hsync_raw, vsync_raw, video_on_raw;
    logic             video_on_d1;
    logic [1:0]       sync_d1_unused;
    color_t           rgb_q;

    assign pix_tick = (div_q == DIV_LAST);

    always_comb begin
        div_d   = pix_tick ? '0 : div_q + 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // frame_tick is registered from next-state values so it lands exactly on
    // the pix_tick cycle of pixel (0, V_VISIBLE) without combinational glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_tick_q <= (div_d == DIV_LAST) && (h_cnt_d == '0) && (v_cnt_d == V_VIS);
        end
    end

    assign hsync_raw    = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_STOP));
    assign vsync_raw    = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_STOP));
    assign video_on_raw = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (2),
        .RST_VAL (3'b110)
    ) u_sync_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  ({hsync_raw, vsync_raw, video_on_raw}),
        .first_o ({sync_d1_unused, video_on_d1}),
        .data_o  ({hsync, vsync, video_on})
    );

`ifdef VGA_TEST_PATTERN_EN
    color_t bar_q;

    // bar_q trails the counter by one clk, matching video_on_d1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_q <= '0;
            rgb_q <= '0;
        end else begin
            bar_q <= h_cnt_q[9:7];
            rgb_q <= video_on_d1 ? bar_q : '0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= video_on_d1 ? color_in : '0;
        end
    end
`endif

    assign pixelX     = h_cnt_q;
    assign pixelY     = v_cnt_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: vector table of timing points, rgb scoreboard, and
// hand sequences for hsync width, a full frame and mid-frame reset.
module tb_vga_sync_gen;
    import vga_pkg::*;

    // Short frame keeps run time small; horizontal timing stays at defaults.
    localparam int TB_V_VIS   = 6;
    localparam int TB_V_FRONT = 2;
    localparam int TB_V_SYNC  = 2;
    localparam int TB_V_BACK  = 2;
    localparam int TB_V_TOTAL = TB_V_VIS + TB_V_FRONT + TB_V_SYNC + TB_V_BACK;
    localparam int TB_H_TOTAL = 800;
    localparam int FRAME_CLK  = TB_H_TOTAL * TB_V_TOTAL * 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  color_in = 3'd0;
    logic [10:0] pixelX;
    logic [9:0]  pixelY;
    logic        hsync, vsync, video_on, frame_tick;
    logic [2:0]  rgb;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .V_VISIBLE (TB_V_VIS),
        .V_FRONT   (TB_V_FRONT),
        .V_SYNC    (TB_V_SYNC),
        .V_BACK    (TB_V_BACK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .color_in   (color_in),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    typedef struct {
        string      name;
        int         x;
        int         y;
        logic [2:0] col;
        logic       hs;
        logic       vs;
        logic       vo;
        logic [2:0] rgb;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         n = 0;
    logic [2:0] exp_rgb[$];
    logic [2:0] col_cur = 3'd0;
    bit         col_rand = 1'b0;
    vec_t       tbl[$];

    function automatic void state_at(input int e, output int x, output int y);
        int k;
        k = e / 2;
        x = k % TB_H_TOTAL;
        y = (k / TB_H_TOTAL) % TB_V_TOTAL;
    endfunction

    function automatic logic hs_raw(input int x);
        return !(x >= 656 && x < 752);
    endfunction

    function automatic logic vs_raw(input int y);
        return !(y >= TB_V_VIS + TB_V_FRONT && y < TB_V_VIS + TB_V_FRONT + TB_V_SYNC);
    endfunction

    function automatic logic vo_raw(input int x, input int y);
        return (x < 640) && (y < TB_V_VIS);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s n=%0d got %0d expected %0d", nm, n, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s n=%0d bound expired", nm, n);
    endtask

    task automatic drive_color(input logic [2:0] c);
        int   xp, yp;
        logic vo1;
        logic [2:0] e;
        color_in = c;
        if (n >= 1) begin
            state_at(n - 1, xp, yp);
            vo1 = vo_raw(xp, yp);
        end else begin
            xp  = 0;
            vo1 = 1'b0;
        end
`ifdef VGA_TEST_PATTERN_EN
        e = vo1 ? 3'(xp / 128) : 3'd0;
`else
        e = vo1 ? c : 3'd0;
`endif
        exp_rgb.push_back(e);
    endtask

    task automatic step();
        int   x, y, x2, y2;
        logic ehs, evs, evo, eft;
        @(posedge clk);
        n++;
        @(negedge clk);
        state_at(n, x, y);
        chk("pixelX", int'(pixelX), x);
        chk("pixelY", int'(pixelY), y);
        if (n >= 2) begin
            state_at(n - 2, x2, y2);
            ehs = hs_raw(x2);
            evs = vs_raw(y2);
            evo = vo_raw(x2, y2);
        end else begin
            ehs = 1'b1;
            evs = 1'b1;
            evo = 1'b0;
        end
        chk("hsync", int'(hsync), int'(ehs));
        chk("vsync", int'(vsync), int'(evs));
        chk("video_on", int'(video_on), int'(evo));
        eft = (n % 2 == 1) && (x == 0) && (y == TB_V_VIS);
        chk("frame_tick", int'(frame_tick), int'(eft));
        if (exp_rgb.size() == 0) fail_now("rgb_scoreboard_empty");
        else chk("rgb", int'(rgb), int'(exp_rgb.pop_front()));
        drive_color(col_rand ? 3'($urandom_range(0, 7)) : col_cur);
    endtask

    task automatic run_to(input int tx, input int ty, input string nm);
        int budget;
        budget = FRAME_CLK + 100;
        while (!(int'(pixelX) == tx && int'(pixelY) == ty) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) fail_now({"timeout_", nm});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pixelX"}, int'(pixelX), 0);
        chk({tag, "_pixelY"}, int'(pixelY), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_video_on"}, int'(video_on), 0);
        chk({tag, "_rgb"}, int'(rgb), 0);
        chk({tag, "_frame_tick"}, int'(frame_tick), 0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        n = 0;
        exp_rgb.delete();
        drive_color(col_cur);
    endtask

    initial begin
        int budget, n656, low, vs_low, ft_cnt, ft_x, ft_y;
        logic [2:0] erg;

        tbl.push_back('{"vis_start",     5,   0,  3'd7, 1'b1, 1'b1, 1'b1, 3'd7});
        tbl.push_back('{"vis_last_px",   639, 0,  3'd5, 1'b1, 1'b1, 1'b1, 3'd5});
        tbl.push_back('{"h_blank_first", 640, 0,  3'd7, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{"h_front_last",  655, 0,  3'd7, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{"hsync_first",   656, 0,  3'd4, 1'b0, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{"hsync_last",    751, 0,  3'd7, 1'b0, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{"h_back_first",  752, 0,  3'd7, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{"h_last",        799, 0,  3'd7, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{"line1_start",   0,   1,  3'd6, 1'b1, 1'b1, 1'b1, 3'd6});
        tbl.push_back('{"vis_last_line", 100, 5,  3'd7, 1'b1, 1'b1, 1'b1, 3'd7});
        tbl.push_back('{"v_blank_first", 100, 6,  3'd7, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{"vsync_first",   0,   8,  3'd7, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{"hv_sync",       700, 9,  3'd7, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{"v_back",        0,   10, 3'd7, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{"frame_last",    639, 11, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0});

        // Asynchronous reset before any clock edge, then held across edges.
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_async");
        repeat (3) @(negedge clk);
        chk_reset("rst_held");
        release_reset();

        foreach (tbl[i]) begin
            col_cur = tbl[i].col;
            run_to(tbl[i].x, tbl[i].y, tbl[i].name);
            step();
            step();
`ifdef VGA_TEST_PATTERN_EN
            erg = tbl[i].vo ? 3'(tbl[i].x / 128) : 3'd0;
`else
            erg = tbl[i].rgb;
`endif
            chk({tbl[i].name, "_hsync"}, int'(hsync), int'(tbl[i].hs));
            chk({tbl[i].name, "_vsync"}, int'(vsync), int'(tbl[i].vs));
            chk({tbl[i].name, "_video_on"}, int'(video_on), int'(tbl[i].vo));
            chk({tbl[i].name, "_rgb"}, int'(rgb), int'(erg));
        end

        // hsync pulse: lag after pixelX reaches 656 and total low width.
        col_rand = 1'b1;
        budget = 2000;
        while (int'(pixelX) != 656 && budget > 0) begin step(); budget--; end
        if (budget == 0) fail_now("timeout_px656");
        n656 = n;
        budget = 10;
        while (hsync && budget > 0) begin step(); budget--; end
        if (budget == 0) fail_now("timeout_hsync_fall");
        chk("hsync_fall_lag", n - n656, 2);
        low = 0;
        budget = 400;
        while (!hsync && budget > 0) begin low++; step(); budget--; end
        if (budget == 0) fail_now("timeout_hsync_rise");
        chk("hsync_low_clk", low, 192);

        // One full frame with random painter colors.
        run_to(0, 0, "frame_start");
        vs_low = 0;
        ft_cnt = 0;
        ft_x = -1;
        ft_y = -1;
        for (int i = 0; i < FRAME_CLK; i++) begin
            step();
            if (!vsync) vs_low++;
            if (frame_tick) begin
                ft_cnt++;
                ft_x = int'(pixelX);
                ft_y = int'(pixelY);
            end
        end
        chk("vsync_low_clk", vs_low, TB_V_SYNC * TB_H_TOTAL * 2);
        chk("frame_tick_count", ft_cnt, 1);
        chk("frame_tick_x", ft_x, 0);
        chk("frame_tick_y", ft_y, TB_V_VIS);

        // Mid-frame reset takes effect between clock edges.
        run_to(300, 5, "mid_frame");
        chk("pre_reset_pixelX", int'(pixelX), 300);
        #1 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        chk_reset("rst_mid_held");
        col_rand = 1'b0;
        col_cur = 3'd7;
        release_reset();
        step();
        chk("restart_x_after_1clk", int'(pixelX), 0);
        step();
        chk("restart_x_after_2clk", int'(pixelX), 1);
        repeat (1597) step();
        chk("restart_x_799", int'(pixelX), 799);
        chk("restart_y_0", int'(pixelY), 0);
        step();
        chk("restart_wrap_x", int'(pixelX), 0);
        chk("restart_wrap_y", int'(pixelY), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
